alu_wide_seq: RTL and testbench

- Multi-cycle sequencer that runs wide (4*NIBBLES-bit) arithmetic and logic operations on the shared 4-bit ALU.
- Processes one nibble per cycle, LSB nibble first, and chains carry/borrow through the ALU carry_f/borrow_f inputs.
- Sits between a valid/ready requester and the combinational ALU; it is the ALU's only driver when instantiated.

---
 rtl/alu_wide_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_wide_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// -----------------------------------------------------------------------------
// alu_wide_seq
//   Runs wide (4*NIBBLES-bit) arithmetic/logic operations on a shared 4-bit
//   combinational ALU, one nibble per clock, LSB nibble first. Carry/borrow
//   is chained between nibbles through the ALU carry_f/borrow_f inputs.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_op, req_cin, req_a/b    operation, carry/borrow in (ADC/SBC), operands
//   rsp_valid/rsp_ready         response handshake
//   rsp_c, rsp_carry, rsp_zero  result, final carry/borrow, zero flag
//   alu_a/b/mode/carry_f/borrow_f  drive to the shared 4-bit ALU
//   alu_c, alu_flags            ALU result and flags ([0] carry, [1] borrow,
//                               [2] zero)
//   rsp_ovf                     signed overflow (only with ALU_WIDE_SEQ_OVF_EN)
//
// Optional feature macro: ALU_WIDE_SEQ_OVF_EN adds the rsp_ovf output.
// -----------------------------------------------------------------------------
module alu_wide_seq #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic         req_cin,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_c,
    output logic         rsp_carry,
    output logic         rsp_zero,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [3:0]   alu_mode,
    output logic         alu_carry_f,
    output logic         alu_borrow_f,
    input  logic [3:0]   alu_c,
    input  logic [3:0]   alu_flags
`ifdef ALU_WIDE_SEQ_OVF_EN
    ,
    output logic         rsp_ovf
`endif
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam logic [3:0] MODE_OFF = 4'b0000;
    localparam logic [3:0] MODE_ADD = 4'b0001;
    localparam logic [3:0] MODE_SUB = 4'b0011;
    localparam logic [3:0] MODE_AND = 4'b0110;
    localparam logic [3:0] MODE_OR  = 4'b0111;
    localparam logic [3:0] MODE_XOR = 4'b1001;
    localparam logic [3:0] MODE_NOT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Map a request opcode onto the ALU mode encoding.
    function automatic logic [3:0] op_to_mode(input logic [2:0] op);
        logic [3:0] mode;
        case (op)
            OP_ADD, OP_ADC: mode = MODE_ADD;
            OP_SUB, OP_SBC: mode = MODE_SUB;
            OP_AND:         mode = MODE_AND;
            OP_OR:          mode = MODE_OR;
            OP_XOR:         mode = MODE_XOR;
            OP_NOT:         mode = MODE_NOT;
            default:        mode = MODE_OFF;
        endcase
        return mode;
    endfunction

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               chain_q, chain_d;
    logic               zacc_q, zacc_d;
    logic [W-1:0]       res_q, res_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [W-1:0]       rsp_c_q, rsp_c_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_ovf_q, rsp_ovf_d;

    logic [3:0]         run_mode_s;
    logic               last_nib_s;
    logic               zacc_next_s;
    logic               chain_next_s;

    assign run_mode_s = op_to_mode(op_q);
    assign last_nib_s = (idx_q == IDX_W'(NIBBLES - 1));

    // ALU drive: only active in RUN, quiet zeros otherwise.
    always_comb begin
        alu_a        = 4'h0;
        alu_b        = 4'h0;
        alu_mode     = MODE_OFF;
        alu_carry_f  = 1'b0;
        alu_borrow_f = 1'b0;
        if (state_q == ST_RUN) begin
            alu_a        = a_q[{idx_q, 2'b00} +: 4];
            alu_b        = b_q[{idx_q, 2'b00} +: 4];
            alu_mode     = run_mode_s;
            alu_carry_f  = (run_mode_s == MODE_ADD) ? chain_q : 1'b0;
            alu_borrow_f = (run_mode_s == MODE_SUB) ? chain_q : 1'b0;
        end else begin
            alu_a = 4'h0;
        end
    end

    // Chain/zero accumulation; only the flag belonging to the active mode is used.
    always_comb begin
        zacc_next_s = zacc_q & alu_flags[2];
        case (run_mode_s)
            MODE_ADD: chain_next_s = alu_flags[0];
            MODE_SUB: chain_next_s = alu_flags[1];
            default:  chain_next_s = 1'b0;
        endcase
    end

    // Next-state logic for the sequencer and response registers.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        chain_d     = chain_q;
        zacc_d      = zacc_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
        rsp_c_d     = rsp_c_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ovf_d   = rsp_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    idx_d   = '0;
                    chain_d = ((req_op == OP_ADC) || (req_op == OP_SBC)) ? req_cin : 1'b0;
                    zacc_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[{idx_q, 2'b00} +: 4] = alu_c;
                zacc_d  = zacc_next_s;
                chain_d = chain_next_s;
                if (last_nib_s) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_c_d     = res_d;
                    rsp_carry_d = chain_next_s;
                    rsp_zero_d  = zacc_next_s;
                    // Signed overflow judged from the operand sign bits and the top result nibble.
                    case (run_mode_s)
                        MODE_ADD: rsp_ovf_d = (a_q[W-1] == b_q[W-1]) & (alu_c[3] != a_q[W-1]);
                        MODE_SUB: rsp_ovf_d = (a_q[W-1] != b_q[W-1]) & (alu_c[3] != a_q[W-1]);
                        default:  rsp_ovf_d = 1'b0;
                    endcase
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'b000;
            idx_q       <= '0;
            chain_q     <= 1'b0;
            zacc_q      <= 1'b1;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            chain_q     <= chain_d;
            zacc_q      <= zacc_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;

`ifdef ALU_WIDE_SEQ_OVF_EN
    assign rsp_ovf = rsp_ovf_q;
`else
    // Overflow register is unused in this build.
    logic unused_ovf_s;
    assign unused_ovf_s = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_seq
//   Directed, table-driven bench for alu_wide_seq (NIBBLES=4) with a
//   behavioural 4-bit ALU. Flags outside the active mode are driven to 1 so
//   that sampling a stale flag shows up as a wrong carry.
// -----------------------------------------------------------------------------
module tb_alu_wide_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic         req_cin;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_c;
    logic         rsp_carry;
    logic         rsp_zero;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_mode;
    logic         alu_carry_f;
    logic         alu_borrow_f;
    logic [3:0]   alu_c;
    logic [3:0]   alu_flags;
    logic         rsp_ovf;

    int checks = 0;
    int errors = 0;

    alu_wide_seq #(.NIBBLES(NIB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_cin      (req_cin),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_c        (rsp_c),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_mode     (alu_mode),
        .alu_carry_f  (alu_carry_f),
        .alu_borrow_f (alu_borrow_f),
        .alu_c        (alu_c),
        .alu_flags    (alu_flags)
`ifdef ALU_WIDE_SEQ_OVF_EN
        ,
        .rsp_ovf      (rsp_ovf)
`endif
    );

`ifndef ALU_WIDE_SEQ_OVF_EN
    assign rsp_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU.
    always_comb begin
        logic [4:0] t;
        t         = 5'd0;
        alu_c     = 4'h0;
        alu_flags = 4'b0011;
        case (alu_mode)
            4'b0001: begin
                t = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carry_f};
                alu_c = t[3:0];
                alu_flags[0] = t[4];
                alu_flags[1] = 1'b1;
            end
            4'b0011: begin
                t = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_borrow_f};
                alu_c = t[3:0];
                alu_flags[0] = 1'b1;
                alu_flags[1] = t[4];
            end
            4'b0110: alu_c = alu_a & alu_b;
            4'b0111: alu_c = alu_a | alu_b;
            4'b1001: alu_c = alu_a ^ alu_b;
            4'b1000: alu_c = ~alu_a;
            default: alu_c = 4'h0;
        endcase
        alu_flags[2] = (alu_c == 4'h0);
        alu_flags[3] = 1'b1;
    end

    typedef struct {
        logic [2:0]   op;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   mode;
        logic [W-1:0] c;
        logic         carry;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, track latency/modes, optionally stall the response.
    task automatic do_op(input vec_t v, input int hold, input bit busy_req);
        int cyc;
        int mode_cnt;
        logic [W-1:0] held_c;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_cin   = v.cin;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        mode_cnt = 0;
        while (!rsp_valid && cyc < 20) begin
            if (alu_mode == v.mode) mode_cnt++;
            @(posedge clk); #1; cyc++;
        end
        chk("latency", cyc, NIB);
        chk("mode_count", mode_cnt, NIB);
        chk("mode_off_done", {28'd0, alu_mode}, 32'd0);
        chk("rsp_c", {16'd0, rsp_c}, {16'd0, v.c});
        chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.carry});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.zero});
`ifdef ALU_WIDE_SEQ_OVF_EN
        chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, v.ovf});
`endif
        held_c = v.c;
        for (int i = 0; i < hold; i++) begin
            if (busy_req) begin
                req_valid = 1'b1;
                req_op    = 3'b000;
                req_a     = 16'h1111;
                req_b     = 16'h2222;
            end
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_c", {16'd0, rsp_c}, {16'd0, held_c});
            chk("hold_ready_low", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        //         op      cin   a         b         mode     c         cy    z     ovf
        vecs[0]  = '{3'b000, 1'b0, 16'h00FF, 16'h0001, 4'b0001, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 1'b0, 16'hFFFF, 16'h0001, 4'b0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'b010, 1'b0, 16'h0000, 16'h0001, 4'b0011, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 1'b0, 16'h1000, 16'h0001, 4'b0011, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 1'b1, 16'h1234, 16'h0000, 4'b0001, 16'h1235, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 1'b1, 16'h1234, 16'h0000, 4'b0011, 16'h1233, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b000, 1'b1, 16'h1234, 16'h0000, 4'b0001, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 1'b0, 16'hA5A5, 16'hFFFF, 4'b1001, 16'h5A5A, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b111, 1'b1, 16'h0F0F, 16'hFFFF, 4'b1000, 16'hF0F0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 1'b0, 16'hF0F0, 16'h0F0F, 4'b0110, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 1'b0, 16'h1200, 16'h0034, 4'b0111, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b001, 1'b1, 16'hFFFF, 16'h0000, 4'b0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{3'b011, 1'b1, 16'h0000, 16'h0000, 4'b0011, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{3'b000, 1'b0, 16'h7FFF, 16'h0001, 4'b0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{3'b010, 1'b0, 16'h8000, 16'h0001, 4'b0011, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{3'b100, 1'b0, 16'h7FFF, 16'h0001, 4'b0110, 16'h0001, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_cin   = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #12;
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_c", {16'd0, rsp_c}, 32'd0);
        chk("reset_carry", {31'd0, rsp_carry}, 32'd0);
        chk("reset_zero", {31'd0, rsp_zero}, 32'd0);
        chk("reset_mode", {28'd0, alu_mode}, 32'd0);
        chk("reset_ovf", {31'd0, rsp_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i], 0, 1'b0);
        end

        // Stalled consumer with a competing request while busy.
        do_op(vecs[7], 3, 1'b1);
        // The ignored busy request must not have started a new op.
        chk("busy_not_accepted", {31'd0, rsp_valid}, 32'd0);
        do_op(vecs[10], 0, 1'b0);

        // Asynchronous reset in the middle of an ADD.
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_cin   = 1'b0;
        req_a     = 16'h00FF;
        req_b     = 16'h0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_run_mode", {28'd0, alu_mode}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mode", {28'd0, alu_mode}, 32'd0);
        chk("abort_c", {16'd0, rsp_c}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op('{3'b000, 1'b0, 16'h0001, 16'h0001, 4'b0001, 16'h0002, 1'b0, 1'b0, 1'b0}, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
